// File: rtl/onehot_ring_decoder_if.sv
// ---------------------------------------------------------------------------
// onehot_ring_decoder_if
// Carries the observed LED ring into the decoder.
//   i_valid : sample strobe. The pattern is only looked at while this is high.
//   i_led   : NB_LEDS-wide observed ring pattern.
// The master modport belongs to the side that drives the ring (the LED shift
// register or a bench). The slave modport belongs to the decoder.
// ---------------------------------------------------------------------------
interface onehot_ring_decoder_if #(
  parameter int NB_LEDS = 12
);

  logic               i_valid;
  logic [NB_LEDS-1:0] i_led;

  modport master (
    output i_valid,
    output i_led
  );

  modport slave (
    input i_valid,
    input i_led
  );

endinterface

// File: rtl/onehot_ring_decoder.sv
// ---------------------------------------------------------------------------
// onehot_ring_decoder
// Watches a rotating one-hot LED ring. Each accepted change must be a
// single-step rotation toward the higher bit index, and the top bit wraps
// back to bit 0. The decoder reports the position, a lock flag, completed
// laps and protocol faults.
// Ports:
//   clk        : system clock. All logic runs on the rising edge.
//   i_rst      : synchronous active-high reset. It has priority over samples.
//   ring       : slave side of onehot_ring_decoder_if (i_valid, i_led).
//   o_pos      : index of the set bit in the last accepted pattern.
//   o_locked   : high while the ring is rotating correctly.
//   o_lap_tick : one-cycle pulse for each wrap from the top bit to bit 0.
//   o_laps     : completed lap count. It wraps modulo 2^NB_LAPS.
//   o_err      : sticky fault flag. Only i_rst clears it.
//   o_err_cnt  : fault count. It saturates at all ones.
// ---------------------------------------------------------------------------
module onehot_ring_decoder #(
  parameter  int NB_LEDS = 12,
  parameter  int NB_LAPS = 8,
  parameter  int NB_ERR  = 4,
  localparam int NB_POS  = $clog2(NB_LEDS)
) (
  input  logic                     clk,
  input  logic                     i_rst,
  onehot_ring_decoder_if.slave     ring,
  output logic [NB_POS-1:0]        o_pos,
  output logic                     o_locked,
  output logic                     o_lap_tick,
  output logic [NB_LAPS-1:0]       o_laps,
  output logic                     o_err,
  output logic [NB_ERR-1:0]        o_err_cnt
);

  localparam logic [NB_POS-1:0] LAST_POS = NB_POS'(NB_LEDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED,
    FAULT
  } state_e;

  state_e               state_q, state_d;
  logic [NB_POS-1:0]    pos_q, pos_d;
  logic                 lapTick_q, lapTick_d;
  logic [NB_LAPS-1:0]   laps_q, laps_d;
  logic                 err_q, err_d;
  logic [NB_ERR-1:0]    errCnt_q, errCnt_d;

  logic                 anySet;
  logic                 multiSet;
  logic                 isOneHot;
  logic [NB_POS-1:0]    ledIdx;
  logic [NB_POS-1:0]    nextPos;
  logic                 isHold;
  logic                 isAdv;

  // Classify the incoming pattern. The scan notes whether any bit is set,
  // whether a second bit shows up, and the index of the set bit. The index
  // is only used when the pattern is one-hot, so the value it takes for
  // multi-bit patterns does not matter.
  always_comb begin
    anySet   = 1'b0;
    multiSet = 1'b0;
    ledIdx   = '0;
    for (int i = 0; i < NB_LEDS; i++) begin
      if (ring.i_led[i]) begin
        if (anySet) begin
          multiSet = 1'b1;
        end
        anySet = 1'b1;
        ledIdx = NB_POS'(i);
      end
    end
    isOneHot = anySet && !multiSet;
  end

  // The expected successor of the stored position wraps explicitly. NB_LEDS
  // need not be a power of two, so letting the counter overflow would be
  // wrong.
  always_comb begin
    nextPos = (pos_q == LAST_POS) ? '0 : pos_q + NB_POS'(1);
    isHold  = isOneHot && (ledIdx == pos_q);
    isAdv   = isOneHot && (ledIdx == nextPos);
  end

  // Next-state logic. Everything holds by default and the lap tick drops.
  // A lap is counted only on a wrap that happens while already locked. A
  // wrap seen during acquisition only establishes lock. Faults are counted
  // once, on the exit from LOCKED, so staying in FAULT adds nothing.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    lapTick_d = 1'b0;
    laps_d    = laps_q;
    err_d     = err_q;
    errCnt_d  = errCnt_q;

    if (ring.i_valid) begin
      unique case (state_q)
        IDLE: begin
          if (isOneHot) begin
            state_d = ACQUIRE;
            pos_d   = ledIdx;
          end
        end

        ACQUIRE: begin
          if (!isOneHot) begin
            state_d = IDLE;
          end else if (isAdv) begin
            state_d = LOCKED;
            pos_d   = ledIdx;
          end else if (!isHold) begin
            pos_d   = ledIdx;
          end
        end

        LOCKED: begin
          if (isAdv) begin
            pos_d = ledIdx;
            if (pos_q == LAST_POS) begin
              lapTick_d = 1'b1;
              laps_d    = laps_q + NB_LAPS'(1);
            end
          end else if (!isHold) begin
            state_d  = FAULT;
            err_d    = 1'b1;
            errCnt_d = (errCnt_q == '1) ? errCnt_q : errCnt_q + NB_ERR'(1);
          end
        end

        FAULT: begin
          if (isOneHot) begin
            state_d = ACQUIRE;
            pos_d   = ledIdx;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers. Reset takes priority over any sample
  // presented on the same edge.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      lapTick_q <= 1'b0;
      laps_q    <= '0;
      err_q     <= 1'b0;
      errCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      lapTick_q <= lapTick_d;
      laps_q    <= laps_d;
      err_q     <= err_d;
      errCnt_q  <= errCnt_d;
    end
  end

  // Every output comes straight from a register. o_locked is a decode of
  // the registered state only.
  always_comb begin
    o_pos      = pos_q;
    o_locked   = (state_q == LOCKED);
    o_lap_tick = lapTick_q;
    o_laps     = laps_q;
    o_err      = err_q;
    o_err_cnt  = errCnt_q;
  end

endmodule
